// File: rtl/matrix_op_ctrl.sv
// Row sequencer for the packed-row element-wise ALU: reads A/B rows, feeds the ALU, writes C rows.
// Optional MATOP_OVF_ABORT_EN: an overflowing row is still written, then the remaining rows are skipped.
//
// state   | meaning
// S_IDLE  | waiting for start; command latched on acceptance
// S_READ  | rd_en high, row addresses of A/B presented
// S_EXEC  | read data valid, passed straight through to the ALU
// S_WRITE | wr_en high, ALU result written to C, overflow accumulated
// S_DONE  | one-cycle completion pulse, busy still high
module matrix_op_ctrl #(
  parameter int ROWS   = 5,
  parameter int ROW_W  = 40,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [2:0]        size_i,
  input  logic [ADDR_W-1:0] base_a_i,
  input  logic [ADDR_W-1:0] base_b_i,
  input  logic [ADDR_W-1:0] base_c_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              ovf_any_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_a_o,
  output logic [ADDR_W-1:0] rd_addr_b_o,
  input  logic [ROW_W-1:0]  rd_data_a_i,
  input  logic [ROW_W-1:0]  rd_data_b_i,
  output logic [ROW_W-1:0]  alu_m1_o,
  output logic [ROW_W-1:0]  alu_m2_o,
  output logic              alu_op_o,
  input  logic [ROW_W-1:0]  alu_out_i,
  input  logic              alu_ovf_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [ROW_W-1:0]  wr_data_o
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WRITE, S_DONE} state_e;

  state_e            state_q;
  logic [2:0]        row_q;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] base_a_q;
  logic [ADDR_W-1:0] base_b_q;
  logic [ADDR_W-1:0] base_c_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              ovf_any_q;
  logic              rd_en_q;
  logic              wr_en_q;
  logic              alu_op_q;
  logic [ADDR_W-1:0] rd_addr_a_q;
  logic [ADDR_W-1:0] rd_addr_b_q;
  logic [ADDR_W-1:0] wr_addr_q;

  logic       cmd_bad;
  logic       last_row;
  logic       wr_last;
  logic [2:0] row_inc;

  assign cmd_bad  = op_i[1] | (size_i == 3'd0) | (int'(size_i) > ROWS);
  assign last_row = (row_q == (size_q - 3'd1));
  assign row_inc  = row_q + 3'd1;

`ifdef MATOP_OVF_ABORT_EN
  assign wr_last = last_row | alu_ovf_i;
`else
  assign wr_last = last_row;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      row_q       <= 3'd0;
      size_q      <= 3'd0;
      base_a_q    <= '0;
      base_b_q    <= '0;
      base_c_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ovf_any_q   <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      alu_op_q    <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      wr_addr_q   <= '0;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            busy_q    <= 1'b1;
            err_q     <= cmd_bad;
            ovf_any_q <= 1'b0;
            alu_op_q  <= op_i[0];
            size_q    <= size_i;
            base_a_q  <= base_a_i;
            base_b_q  <= base_b_i;
            base_c_q  <= base_c_i;
            row_q     <= 3'd0;
            if (cmd_bad) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= S_READ;
              rd_en_q     <= 1'b1;
              rd_addr_a_q <= base_a_i;
              rd_addr_b_q <= base_b_i;
            end
          end
        end
        S_READ: state_q <= S_EXEC;
        S_EXEC: begin
          state_q   <= S_WRITE;
          wr_en_q   <= 1'b1;
          wr_addr_q <= base_c_q + ADDR_W'(row_q);
        end
        S_WRITE: begin
          ovf_any_q <= ovf_any_q | alu_ovf_i;
          if (wr_last) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q     <= S_READ;
            row_q       <= row_inc;
            rd_en_q     <= 1'b1;
            rd_addr_a_q <= base_a_q + ADDR_W'(row_inc);
            rd_addr_b_q <= base_b_q + ADDR_W'(row_inc);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Operands and result are not re-registered; the row memory and ALU supply the pipeline stages.
  assign alu_m1_o    = rd_data_a_i;
  assign alu_m2_o    = rd_data_b_i;
  assign wr_data_o   = alu_out_i;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign ovf_any_o   = ovf_any_q;
  assign rd_en_o     = rd_en_q;
  assign wr_en_o     = wr_en_q;
  assign alu_op_o    = alu_op_q;
  assign rd_addr_a_o = rd_addr_a_q;
  assign rd_addr_b_o = rd_addr_b_q;
  assign wr_addr_o   = wr_addr_q;

endmodule
